// File: rtl/seg_anim_pkg.sv
// Shared types and constants for the seg_anim_seq 7-segment animation sequencer.
package seg_anim_pkg;

    typedef enum logic [1:0] {
        FWD      = 2'b00,
        REV      = 2'b01,
        PINGPONG = 2'b10,
        HOLD     = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Frames walk the outer ring a..f; g marks the second lap and beyond.
    localparam int PATTERN_CYCLE = 6;

    localparam logic [6:0] SEG_RESET = 7'h01;

endpackage

// File: rtl/seg_frame_rom.sv
// Combinational frame-index to segment-pattern lookup for seg_anim_seq.
module seg_frame_rom
    import seg_anim_pkg::*;
#(
    parameter int N_FRAMES = 6,
    parameter int SEG_W    = 7
) (
    input  logic [$clog2(N_FRAMES)-1:0] idx,
    output logic [SEG_W-1:0]            pattern
);

    int idx_i;
    int pos;

    always_comb begin
        pattern = '0;
        idx_i   = int'(idx);
        pos     = idx_i % PATTERN_CYCLE;
        for (int b = 0; b < SEG_W; b++) begin
            if (b == pos) pattern[b] = 1'b1;
            if (b == SEG_G && idx_i >= PATTERN_CYCLE) pattern[b] = 1'b1;
        end
    end

endmodule

// File: rtl/seg_anim_seq.sv
// Parametrised 7-segment animation sequencer (forward/reverse/ping-pong/hold).
// Defining SEG_ANIM_DP_EN adds a dp output that toggles on every sequence wrap.
module seg_anim_seq
    import seg_anim_pkg::*;
#(
    parameter int N_FRAMES = 6,
    parameter int DIV_W    = 8,
    parameter int SEG_W    = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        clear,
    input  logic                        run,
    input  logic [1:0]                  mode,
    input  logic [DIV_W-1:0]            period,
`ifdef SEG_ANIM_DP_EN
    output logic                        dp,
`endif
    output logic [SEG_W-1:0]            segments,
    output logic [$clog2(N_FRAMES)-1:0] frame,
    output logic                        step_pulse
);

    // state | meaning
    // IDLE  | after reset/clear, waiting for run
    // RUN   | prescaler counting, frames stepping
    // PAUSE | run dropped, frame held
    localparam int FW = $clog2(N_FRAMES);
    localparam logic [FW-1:0] LAST = FW'(N_FRAMES - 1);

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [FW-1:0]     frame_nxt;
    logic              dir_up, dir_nxt;
    logic              pulse_nxt;
    logic              step_due;
    logic [SEG_W-1:0]  rom_pattern;

    assign step_due = (cnt >= period);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        frame_nxt = frame;
        dir_nxt   = dir_up;
        pulse_nxt = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            frame_nxt = '0;
            dir_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (run) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_nxt = PAUSE;
                    end else if (step_due) begin
                        cnt_nxt = '0;
                        case (mode_t'(mode))
                            FWD: begin
                                frame_nxt = (frame == LAST) ? '0 : frame + FW'(1);
                                pulse_nxt = 1'b1;
                            end
                            REV: begin
                                frame_nxt = (frame == '0) ? LAST : frame - FW'(1);
                                pulse_nxt = 1'b1;
                            end
                            PINGPONG: begin
                                pulse_nxt = 1'b1;
                                if (dir_up) begin
                                    if (frame == LAST) begin
                                        dir_nxt   = 1'b0;
                                        frame_nxt = LAST - FW'(1);
                                    end else begin
                                        frame_nxt = frame + FW'(1);
                                    end
                                end else begin
                                    if (frame == '0) begin
                                        dir_nxt   = 1'b1;
                                        frame_nxt = FW'(1);
                                    end else begin
                                        frame_nxt = frame - FW'(1);
                                    end
                                end
                            end
                            HOLD: frame_nxt = frame;
                        endcase
                    end else begin
                        cnt_nxt = cnt + DIV_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Segments come from the next-frame value so they never lag frame.
    seg_frame_rom #(
        .N_FRAMES (N_FRAMES),
        .SEG_W    (SEG_W)
    ) u_rom (
        .idx     (frame_nxt),
        .pattern (rom_pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= '0;
            dir_up     <= 1'b1;
            step_pulse <= 1'b0;
            segments   <= SEG_W'(SEG_RESET);
        end else if (ena) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            frame      <= frame_nxt;
            dir_up     <= dir_nxt;
            step_pulse <= pulse_nxt;
            segments   <= rom_pattern;
        end
    end

`ifdef SEG_ANIM_DP_EN
    logic wrap;

    always_comb begin
        wrap = 1'b0;
        if (state == RUN && run && step_due) begin
            case (mode_t'(mode))
                FWD:      wrap = (frame == LAST);
                REV:      wrap = (frame == '0);
                PINGPONG: wrap = dir_up ? (frame == LAST) : (frame == '0);
                default:  wrap = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= 1'b0;
        end else if (ena) begin
            if (clear)     dp <= 1'b0;
            else if (wrap) dp <= ~dp;
        end
    end
`endif

endmodule

// File: tb/tb_seg_anim_seq.sv
// Randomised self-checking bench for seg_anim_seq against a frame-level reference model.
module tb_seg_anim_seq;

    localparam int N  = 6;
    localparam int DW = 8;
    localparam int SW = 7;
    localparam int FW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          clear;
    logic          run;
    logic [1:0]    mode;
    logic [DW-1:0] period;
    logic [SW-1:0] segments;
    logic [FW-1:0] frame;
    logic          step_pulse;
`ifdef SEG_ANIM_DP_EN
    logic          dp;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 paused.
    int m_phase, m_cnt, m_frame, m_dir, m_pulse, m_dp;

    always #5 clk = ~clk;

    seg_anim_seq #(
        .N_FRAMES (N),
        .DIV_W    (DW),
        .SEG_W    (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .run        (run),
        .mode       (mode),
        .period     (period),
`ifdef SEG_ANIM_DP_EN
        .dp         (dp),
`endif
        .segments   (segments),
        .frame      (frame),
        .step_pulse (step_pulse)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int seg_of(input int f);
        return (1 << (f % 6)) | ((f >= 6) ? 64 : 0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_frame = 0; m_dir = 1; m_pulse = 0; m_dp = 0;
    endtask

    task automatic model_step();
        int nf;
        bit wrapped;
        wrapped = 0;
        if (!ena) return;
        if (clear) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (m_phase != 1) begin
            if (run) begin m_phase = 1; m_cnt = 0; end
        end else if (!run) begin
            m_phase = 2;
        end else if (m_cnt >= int'(period)) begin
            m_cnt = 0;
            case (mode)
                2'd0: begin wrapped = (m_frame == N - 1); m_frame = (m_frame + 1) % N; end
                2'd1: begin wrapped = (m_frame == 0); m_frame = (m_frame + N - 1) % N; end
                2'd2: begin
                    nf = m_frame + (m_dir ? 1 : -1);
                    if (nf < 0 || nf >= N) begin
                        m_dir   = 1 - m_dir;
                        nf      = m_frame + (m_dir ? 1 : -1);
                        wrapped = 1;
                    end
                    m_frame = nf;
                end
                default: ;
            endcase
            if (mode != 2'd3) m_pulse = 1;
            if (wrapped) m_dp = 1 - m_dp;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic compare_all();
        check_eq("frame", int'(frame), m_frame);
        check_eq("segments", int'(segments), seg_of(m_frame));
        check_eq("step_pulse", int'(step_pulse), m_pulse);
`ifdef SEG_ANIM_DP_EN
        check_eq("dp", int'(dp), m_dp);
`endif
    endtask

    // Called at a falling edge with inputs already set for the coming rising edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    int pp_seq [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};

    initial begin
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0; run = 1'b0; mode = 2'd0; period = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check_eq("rst_segments", int'(segments), 'h01);
        rst_n = 1'b1;

        // Forward, period 2: each frame lasts 3 clocks.
        run = 1'b1; mode = 2'd0; period = 8'd2;
        tick();
        for (int i = 1; i <= 18; i++) begin
            tick();
            check_eq("fwd_frame", int'(frame), (i / 3) % 6);
            check_eq("fwd_pulse", int'(step_pulse), (i % 3 == 0) ? 1 : 0);
            if (i == 9) check_eq("fwd_seg_f3", int'(segments), 'h08);
        end

        // Reverse from reset state, period 0.
        do_clear();
        mode = 2'd1; period = 8'd0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("rev_frame", int'(frame), 6 - i);
        end

        // Ping-pong, period 0.
        do_clear();
        mode = 2'd2;
        tick();
        for (int i = 0; i < 11; i++) begin
            tick();
            check_eq("pp_frame", int'(frame), pp_seq[i]);
        end

        // Clear during descent, then ascend from 0 again.
        for (int i = 0; i < 20 && !(m_dir == 0 && m_frame == 3); i++) tick();
        check_eq("pp_descent_reached", int'(frame), 3);
        do_clear();
        check_eq("clr_frame", int'(frame), 0);
        tick();
        tick();
        check_eq("clr_step1", int'(frame), 1);
        tick();
        check_eq("clr_step2", int'(frame), 2);

        // Pause at frame 2, then hold mode.
        do_clear();
        mode = 2'd0; period = 8'd0;
        repeat (3) tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("pause_frame", int'(frame), 2);
        end
        run = 1'b1; mode = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_frame", int'(frame), 2);
            check_eq("hold_pulse", int'(step_pulse), 0);
        end

        // ena low 5 clocks mid-frame, period 3: step moves from tick 4 to tick 9.
        do_clear();
        mode = 2'd0; period = 8'd3;
        tick();
        for (int i = 1; i <= 9; i++) begin
            ena = (i >= 3 && i <= 7) ? 1'b0 : 1'b1;
            tick();
            check_eq("ena_frame", int'(frame), (i == 9) ? 1 : 0);
            check_eq("ena_pulse", int'(step_pulse), (i == 9) ? 1 : 0);
        end
        ena = 1'b1;

        // Asynchronous reset at frame 4.
        do_clear();
        period = 8'd0;
        for (int i = 0; i < 10 && m_frame != 4; i++) tick();
        check_eq("arst_at4", int'(frame), 4);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_eq("arst_frame", int'(frame), 0);
        check_eq("arst_segments", int'(segments), 'h01);
        check_eq("arst_pulse", int'(step_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Randomised run.
        run = 1'b1; period = 8'd1;
        for (int i = 0; i < 3000; i++) begin
            ena   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)
                period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
            tick();
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_anim_seq.md
# seg_anim_seq

Parametrised 7-segment animation sequencer: steps a frame index through N_FRAMES frames at a programmable rate, in forward, reverse, ping-pong or hold mode, and drives registered segment patterns. Generalises the single fixed dance pattern of our top-level into a reusable block. It sits between the `ui_in` control bits and `uo_out[6:0]` in the tile top.

## Interface
- `N_FRAMES`, 6: number of frames; legal range 2..64.
- `DIV_W`, 8: width of the step-period input and the prescaler counter.
- `SEG_W`, 7: segment output width; bit 0 = a … bit 6 = g.
- `clk`  in  1  system clock; the block uses this single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable; 0 freezes every register.
- `clear`  in  1  synchronous clear to the reset state.
- `run`  in  1  1 = animate, 0 = pause on the current frame.
- `mode`  in  2  00 forward, 01 reverse, 10 ping-pong, 11 hold.
- `period`  in  DIV_W  clocks per frame minus one.
- `segments`  out  SEG_W  registered pattern of the current frame.
- `frame`  out  clog2(N_FRAMES)  current frame index.
- `step_pulse`  out  1  one-cycle pulse in the first cycle of each new frame.

## Operation
- Reset values: `frame`=0, `segments`=7'h01, `step_pulse`=0, prescaler=0, `dir_up`=1, state IDLE.
- Pattern: frame i lights segment (i mod 6), which is `1 << (i mod 6)`. Segment g lights as well when i ≥ 6.
- States:
  - IDLE: entered from reset or `clear`.
  - RUN: entered from IDLE or PAUSE when `run`=1; the prescaler clears on entry.
  - PAUSE: entered from RUN when `run`=0; the frame is held, not reset.
- Priority: `rst_n` > `ena`=0 (freeze) > `clear` > `run`/step logic.
- Prescaler: counts up in RUN.
  - When the count is ≥ `period`, a step occurs and the count returns to 0.
  - `period`=0 gives a step every clock.
  - A `period` change takes effect immediately through the ≥ compare.
- Step rules:
  - forward: frame+1, wrapping N_FRAMES-1→0.
  - reverse: frame-1, wrapping 0→N_FRAMES-1.
  - ping-pong: moves in the direction `dir_up`. At N_FRAMES-1 going up, `dir_up` flips to 0 and the next frame is N_FRAMES-2. At 0 going down, `dir_up` flips to 1 and the next frame is 1.
  - hold: the prescaler runs, the frame is unchanged, and no `step_pulse` is raised.
- `dir_up` changes only in ping-pong; other modes keep it.
- A `mode` change applies at the next step.
- `clear` restores every reset value in the following cycle, including `dir_up`=1.

## Timing
- Step latency: when the count reaches `period` at edge k, `frame`, `segments` and `step_pulse` all update at edge k+1.
- `segments` is registered from the next-frame ROM value, so it is never skewed from `frame`.
- `step_pulse` is high for exactly one cycle per frame change.
- `run` rising: the first step comes `period`+1 clocks after RUN is entered.
- `run` falling: any step pending in that same cycle is dropped.
- `ena`=0: all outputs hold, including `step_pulse`.
- Async reset mid-run: outputs go to their reset values without waiting for a clock edge.

## Configuration
- `SEG_ANIM_DP_EN` defined:
  - Adds output `dp` (1 bit, reset 0).
  - `dp` toggles on every sequence wrap: the forward wrap, the reverse wrap, and each ping-pong turnaround.
  - `dp` updates in the same cycle as `frame`.
- Undefined: there is no `dp` port and no associated logic.

## Structure
- Package `seg_anim_pkg` holds:
  - the mode enum (FWD, REV, PINGPONG, HOLD);
  - the state enum (IDLE, RUN, PAUSE);
  - the segment bit-position constants;
  - the `SEG_RESET` constant (7'h01).
- Sub-module `seg_frame_rom` is a combinational frame-index→pattern lookup, parametrised by `N_FRAMES` and `SEG_W`.

## Test plan
- Forward, N_FRAMES=6, period=2, run=1: frame sequence 0,1,2,3,4,5,0 with each frame lasting 3 clocks; `step_pulse` every 3rd clock; `segments` at frame 3 = 7'h08.
- Reverse from reset, period=0: frames 5,4,3 on consecutive clocks.
- Ping-pong, period=0: frames 1,2,3,4,5,4,3,2,1,0,1. With `SEG_ANIM_DP_EN` defined, `dp` toggles at 5→4 and again at 0→1.
- Pause and mode change: `run` drops at frame 2 and the frame holds at 2 for 10 clocks. With `run` high again and mode=hold, the frame stays at 2 and `step_pulse` stays 0.
- `ena`=0 for 5 clocks mid-frame, period=3: the step completes exactly 5 clocks later than it would have otherwise.
- Reset and clear:
  - `rst_n` low asynchronously at frame 4 gives `frame`=0 and `segments`=7'h01 before the next clock edge.
  - `clear` during ping-pong descent gives frame 0 with `dir_up`=1, and the next steps are 1,2.
